ysyx_25040129_lsu_unit: RTL and testbench
=========================================

// Module: ysyx_25040129_lsu_unit
// PURPOSE
//  Load/store unit. It is the responder end of the EXU->LSU valid/ready request channel.
//  Accepts one EXU request at a time. It either passes the ALU result through, or performs one aligned bus
//  access and returns sign/zero-extended load data.
//  Presents the completed result to WBU through a valid/ready output register.
//  Flags misaligned, bus-error and timed-out accesses instead of writing the register file.
// PARAMETERS
//  RD_W          4    width of rd index (RV32E)
//  TIMEOUT_CYC   255  max cycles in WAIT before fault; 0 disables timeout; counter width 8
// PORTS
//  clk                       in   1     clock, all state on rising edge
//  rst                       in   1     asynchronous, active-high reset
//  is_req_valid_from_exu     in   1     EXU request valid
//  is_req_ready_to_exu       out  1     LSU can accept request this cycle
//  result_in_lsu             in   32    ALU result = effective address, or pass-through value
//  lsu_write_data_in_lsu     in   32    store data (rs2)
//  lsu_read_in_lsu           in   3     0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6-7 treated as none
//  lsu_write_in_lsu          in   2     0 none, 1 SB, 2 SH, 3 SW
//  rd_in_lsu                 in   RD_W  destination register
//  reg_write_in_lsu          in   1     register write enable
//  mem_req_valid             out  1     bus request valid
//  mem_req_ready             in   1     bus accepts request
//  mem_addr                  out  32    word-aligned address {addr[31:2],2'b0}
//  mem_wen                   out  1     1 = write
//  mem_wdata                 out  32    store data lane-shifted
//  mem_wstrb                 out  4     byte strobes
//  mem_rsp_valid             in   1     response / write ack
//  mem_rsp_rdata             in   32    read data
//  mem_rsp_err               in   1     bus error with response
//  is_req_valid_to_wbu       out  1     output register valid
//  is_req_ready_from_wbu     in   1     WBU consumes output
//  result_out_lsu            out  32    final writeback value
//  rd_out_lsu                out  RD_W  destination register
//  reg_write_out_lsu         out  1     write enable, forced 0 on fault
//  access_fault_out_lsu      out  1     misaligned / bus error / timeout
//  is_data_forward_valid_from_lsu out 1 result_out_lsu is final, usable for bypass (= is_req_valid_to_wbu)
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, timeout counter 0. Reset mid-access abandons it.
//  A late mem_rsp_valid seen in IDLE is ignored.
//  States: IDLE, REQ, WAIT, DONE.
//  is_req_ready_to_exu = (IDLE) | (DONE & is_req_ready_from_wbu); accept = valid_from_exu & ready_to_exu.
//  On accept, latch all inputs. The next state depends on the access type:
//   - No read and no write: DONE next cycle, result = result_in_lsu. Latency is 1.
//   - Misaligned (LH/LHU/SH with addr[0]; LW/SW with addr[1:0]!=0): DONE, fault=1, reg_write_out=0.
//     No bus request is issued.
//   - Otherwise: REQ.
//   - Read and write both nonzero: treated as the read; the write is ignored.
//  REQ: mem_req_valid=1, with addr/wen/wdata/wstrb held stable until mem_req_ready. Then go to WAIT.
//  WAIT: mem_req_valid=0; counter increments each cycle. Exit conditions:
//   - On mem_rsp_valid: DONE; fault=mem_rsp_err; reg_write_out=reg_write & !err.
//   - If TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC: DONE, fault=1.
//     The WAIT exit that rsp_valid or timeout leads to stays DONE; the response arriving in IDLE is ignored.
//  DONE: is_req_valid_to_wbu=1; outputs held until is_req_ready_from_wbu.
//   - Then go to IDLE, or accept a new request in the same cycle (back-to-back).
//  Store strobes and data:
//   - SB: wstrb=4'b0001<<a[1:0], wdata={4{d[7:0]}}.
//   - SH: wstrb=4'b0011<<{a[1],1'b0}, wdata={2{d[15:0]}}.
//   - SW: wstrb=4'hF, wdata=d. Loads: wstrb=0, wen=0.
//  Loads: lane = rdata >> (8*a[1:0]). LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW unmodified.
//  Stores complete on write ack; result_out_lsu=result_in_lsu, reg_write_out=reg_write_in & !fault.
//  Only one access is outstanding; EXU is back-pressured in REQ and WAIT.
// TESTING
//  1. ADD pass-through, result 0x1234, wbu ready -> valid_to_wbu 1 cycle after accept, result 0x1234, no mem_req.
//  2. LB addr 0x8000_0003, rdata 0x80FF_FF7F -> mem_addr 0x8000_0000, result 0xFFFF_FF80.
//     LBU same -> result 0x0000_0080.
//  3. SH addr 0x102, data 0xABCD -> wstrb 4'b1100, wdata 0xABCD_ABCD, wen 1; completes on ack, reg_write_out 0.
//  4. LW addr 0x101 -> no mem_req_valid, fault 1, reg_write_out 0.
//     mem_rsp_err on LW 0x100 -> fault 1.
//  5. WBU ready low 3 cycles in DONE -> outputs stable, ready_to_exu 0; a new request is accepted the cycle ready rises.
//  6. No rsp with TIMEOUT_CYC=4 -> fault after 4 WAIT cycles.
//     Assert rst during WAIT -> IDLE, all outputs 0; a later rsp is ignored.

Source files
------------

// File: rtl/ysyx_25040129_lsu_unit.sv
// -----------------------------------------------------------------------------
// ysyx_25040129_lsu_unit
//
// Load/store unit sitting between EXU and WBU.
//
// It accepts one EXU request at a time. A request either passes the ALU result
// straight through, or performs one aligned bus access. Load data comes back
// sign- or zero-extended. The finished result is held in an output register
// until WBU takes it. Misaligned, bus-error and timed-out accesses raise
// access_fault_out_lsu and suppress the register-file write.
//
// Ports
//   clk, rst                         clock; asynchronous active-high reset
//   is_req_valid_from_exu / is_req_ready_to_exu
//                                    EXU -> LSU request handshake
//   result_in_lsu                    effective address or pass-through value
//   lsu_write_data_in_lsu            store data (rs2)
//   lsu_read_in_lsu                  0 none,1 LB,2 LH,3 LW,4 LBU,5 LHU,6-7 none
//   lsu_write_in_lsu                 0 none,1 SB,2 SH,3 SW
//   rd_in_lsu, reg_write_in_lsu      destination register and its write enable
//   mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wstrb
//                                    bus request channel (word-aligned address)
//   mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
//                                    bus response / write acknowledge
//   is_req_valid_to_wbu / is_req_ready_from_wbu
//                                    LSU -> WBU output handshake
//   result_out_lsu, rd_out_lsu, reg_write_out_lsu, access_fault_out_lsu
//                                    completed writeback information
//   is_data_forward_valid_from_lsu   result_out_lsu is final (bypass enable)
// -----------------------------------------------------------------------------
module ysyx_25040129_lsu_unit #(
    parameter int RD_W        = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    // EXU request channel
    input  logic            is_req_valid_from_exu,
    output logic            is_req_ready_to_exu,
    input  logic [31:0]     result_in_lsu,
    input  logic [31:0]     lsu_write_data_in_lsu,
    input  logic [2:0]      lsu_read_in_lsu,
    input  logic [1:0]      lsu_write_in_lsu,
    input  logic [RD_W-1:0] rd_in_lsu,
    input  logic            reg_write_in_lsu,
    // memory bus
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [31:0]     mem_addr,
    output logic            mem_wen,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_rdata,
    input  logic            mem_rsp_err,
    // WBU output channel
    output logic            is_req_valid_to_wbu,
    input  logic            is_req_ready_from_wbu,
    output logic [31:0]     result_out_lsu,
    output logic [RD_W-1:0] rd_out_lsu,
    output logic            reg_write_out_lsu,
    output logic            access_fault_out_lsu,
    output logic            is_data_forward_valid_from_lsu
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
    localparam logic       TIMEOUT_EN  = (TIMEOUT_CYC != 0);

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LW  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    localparam logic [1:0] ST_SB = 2'd1;
    localparam logic [1:0] ST_SH = 2'd2;
    localparam logic [1:0] ST_SW = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]      state_q,     state_d;
    logic [31:0]     addr_q,      addr_d;
    logic [2:0]      ld_op_q,     ld_op_d;     // 0 when the access is not a load
    logic            wen_q,       wen_d;
    logic [3:0]      wstrb_q,     wstrb_d;
    logic [31:0]     wdata_q,     wdata_d;
    logic [RD_W-1:0] rd_q,        rd_d;
    logic            reg_wr_q,    reg_wr_d;
    logic [31:0]     result_q,    result_d;
    logic            fault_q,     fault_d;
    logic [7:0]      cnt_q,       cnt_d;

    // ------------------------------------------------------------------
    // Request decode (from the EXU inputs, used only on accept)
    // ------------------------------------------------------------------
    logic        in_is_load;
    logic        in_is_store;
    logic        in_is_half;
    logic        in_is_word;
    logic        in_misaligned;
    logic [3:0]  in_wstrb;
    logic [31:0] in_wdata;

    // Codes 6 and 7 are not loads; a valid load code hides any store code.
    assign in_is_load  = (lsu_read_in_lsu >= LD_LB) && (lsu_read_in_lsu <= LD_LHU);
    assign in_is_store = !in_is_load && (lsu_write_in_lsu != 2'd0);

    assign in_is_half = in_is_load ? ((lsu_read_in_lsu == LD_LH) || (lsu_read_in_lsu == LD_LHU))
                                   : (in_is_store && (lsu_write_in_lsu == ST_SH));
    assign in_is_word = in_is_load ? (lsu_read_in_lsu == LD_LW)
                                   : (in_is_store && (lsu_write_in_lsu == ST_SW));

    assign in_misaligned = (in_is_half && result_in_lsu[0])
                         || (in_is_word && (result_in_lsu[1:0] != 2'b00));

    // Store lane placement: data is replicated across all lanes and the
    // strobes pick the bytes the slave actually writes.
    always_comb begin
        in_wstrb = 4'b0000;
        in_wdata = 32'd0;
        if (in_is_store) begin
            case (lsu_write_in_lsu)
                ST_SB: begin
                    in_wstrb = 4'b0001 << result_in_lsu[1:0];
                    in_wdata = {4{lsu_write_data_in_lsu[7:0]}};
                end
                ST_SH: begin
                    in_wstrb = 4'b0011 << {result_in_lsu[1], 1'b0};
                    in_wdata = {2{lsu_write_data_in_lsu[15:0]}};
                end
                ST_SW: begin
                    in_wstrb = 4'b1111;
                    in_wdata = lsu_write_data_in_lsu;
                end
                default: begin
                    in_wstrb = 4'b0000;
                    in_wdata = 32'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load data extraction from the response word
    // ------------------------------------------------------------------
    logic [31:0] rsp_lane;
    logic [31:0] load_value;

    assign rsp_lane = mem_rsp_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_value = rsp_lane;
        case (ld_op_q)
            LD_LB:   load_value = {{24{rsp_lane[7]}},  rsp_lane[7:0]};
            LD_LH:   load_value = {{16{rsp_lane[15]}}, rsp_lane[15:0]};
            LD_LW:   load_value = rsp_lane;
            LD_LBU:  load_value = {24'd0, rsp_lane[7:0]};
            LD_LHU:  load_value = {16'd0, rsp_lane[15:0]};
            default: load_value = rsp_lane;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic accept;
    logic [7:0] cnt_inc;

    assign is_req_ready_to_exu = (state_q == S_IDLE)
                               || ((state_q == S_DONE) && is_req_ready_from_wbu);
    assign accept  = is_req_valid_from_exu && is_req_ready_to_exu;
    assign cnt_inc = cnt_q + 8'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ld_op_d  = ld_op_q;
        wen_d    = wen_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        reg_wr_d = reg_wr_q;
        result_d = result_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_DONE) && is_req_ready_from_wbu) begin
                    state_d = S_IDLE;
                end
                // Accepting here also covers the back-to-back case where WBU
                // drains the previous result in the same cycle.
                if (accept) begin
                    addr_d   = result_in_lsu;
                    ld_op_d  = in_is_load ? lsu_read_in_lsu : 3'd0;
                    wen_d    = in_is_store;
                    wstrb_d  = in_wstrb;
                    wdata_d  = in_wdata;
                    rd_d     = rd_in_lsu;
                    reg_wr_d = reg_write_in_lsu;
                    result_d = result_in_lsu;
                    fault_d  = in_misaligned;
                    cnt_d    = 8'd0;
                    // Pass-through and misaligned requests never touch the bus.
                    if ((!in_is_load && !in_is_store) || in_misaligned) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end
            end

            S_WAIT: begin
                // A response in the same cycle as the timeout wins.
                if (mem_rsp_valid) begin
                    state_d = S_DONE;
                    fault_d = mem_rsp_err;
                    if (!mem_rsp_err && (ld_op_q != 3'd0)) begin
                        result_d = load_value;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (TIMEOUT_EN && (cnt_inc == TIMEOUT_LIM)) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            ld_op_q  <= 3'd0;
            wen_q    <= 1'b0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            rd_q     <= '0;
            reg_wr_q <= 1'b0;
            result_q <= 32'd0;
            fault_q  <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            ld_op_q  <= ld_op_d;
            wen_q    <= wen_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            reg_wr_q <= reg_wr_d;
            result_q <= result_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;

    assign is_req_valid_to_wbu            = (state_q == S_DONE);
    assign is_data_forward_valid_from_lsu = (state_q == S_DONE);
    assign result_out_lsu                 = result_q;
    assign rd_out_lsu                     = rd_q;
    assign access_fault_out_lsu           = fault_q;
    assign reg_write_out_lsu              = (state_q == S_DONE) && reg_wr_q && !fault_q;

endmodule

// File: tb/tb_ysyx_25040129_lsu_unit.sv
module tb_ysyx_25040129_lsu_unit;

    localparam int RD_W = 4;
    localparam int TO   = 4;

    logic            clk;
    logic            rst;
    logic            is_req_valid_from_exu;
    logic            is_req_ready_to_exu;
    logic [31:0]     result_in_lsu;
    logic [31:0]     lsu_write_data_in_lsu;
    logic [2:0]      lsu_read_in_lsu;
    logic [1:0]      lsu_write_in_lsu;
    logic [RD_W-1:0] rd_in_lsu;
    logic            reg_write_in_lsu;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [31:0]     mem_addr;
    logic            mem_wen;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_rdata;
    logic            mem_rsp_err;
    logic            is_req_valid_to_wbu;
    logic            is_req_ready_from_wbu;
    logic [31:0]     result_out_lsu;
    logic [RD_W-1:0] rd_out_lsu;
    logic            reg_write_out_lsu;
    logic            access_fault_out_lsu;
    logic            is_data_forward_valid_from_lsu;

    int total = 0;
    int bad   = 0;
    int txn_no = 0;

    ysyx_25040129_lsu_unit #(.RD_W(RD_W), .TIMEOUT_CYC(TO)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .is_req_valid_from_exu          (is_req_valid_from_exu),
        .is_req_ready_to_exu            (is_req_ready_to_exu),
        .result_in_lsu                  (result_in_lsu),
        .lsu_write_data_in_lsu          (lsu_write_data_in_lsu),
        .lsu_read_in_lsu                (lsu_read_in_lsu),
        .lsu_write_in_lsu               (lsu_write_in_lsu),
        .rd_in_lsu                      (rd_in_lsu),
        .reg_write_in_lsu               (reg_write_in_lsu),
        .mem_req_valid                  (mem_req_valid),
        .mem_req_ready                  (mem_req_ready),
        .mem_addr                       (mem_addr),
        .mem_wen                        (mem_wen),
        .mem_wdata                      (mem_wdata),
        .mem_wstrb                      (mem_wstrb),
        .mem_rsp_valid                  (mem_rsp_valid),
        .mem_rsp_rdata                  (mem_rsp_rdata),
        .mem_rsp_err                    (mem_rsp_err),
        .is_req_valid_to_wbu            (is_req_valid_to_wbu),
        .is_req_ready_from_wbu          (is_req_ready_from_wbu),
        .result_out_lsu                 (result_out_lsu),
        .rd_out_lsu                     (rd_out_lsu),
        .reg_write_out_lsu              (reg_write_out_lsu),
        .access_fault_out_lsu           (access_fault_out_lsu),
        .is_data_forward_valid_from_lsu (is_data_forward_valid_from_lsu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed results of the most recent transaction, for literal checks.
    logic [31:0] last_result;
    logic        last_fault;
    logic        last_rw;

    // Behavioural reference: what the access should look like on the bus and
    // what WBU should receive, derived from access size and byte offset.
    task automatic model(input logic [2:0] rop, input logic [1:0] wop,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rdata, input logic err,
                         input int delay, input logic rw,
                         output bit bus, output bit wen, output logic [3:0] strb,
                         output logic [31:0] wdata, output logic [31:0] res,
                         output bit flt, output bit rwo, output int waitc);
        int off, size;
        bit is_ld, is_st, sgn;
        logic [31:0] v;
        off   = int'(a % 4);
        is_ld = (rop >= 1) && (rop <= 5);
        is_st = !is_ld && (wop != 0);
        sgn   = (rop == 1) || (rop == 2);
        if (is_ld)      size = (rop == 1 || rop == 4) ? 1 : (rop == 3) ? 4 : 2;
        else if (is_st) size = (wop == 1) ? 1 : (wop == 2) ? 2 : 4;
        else            size = 0;
        bus = 0; wen = 0; strb = 4'd0; wdata = 32'd0; res = a; flt = 0; waitc = 0;
        if (size == 0) begin
            flt = 0;
        end else if ((off % size) != 0) begin
            flt = 1;
        end else begin
            bus  = 1;
            wen  = is_st;
            if (is_st) begin
                strb = 4'(((1 << size) - 1) << off);
                if (size == 1)      wdata = (d & 32'hFF) * 32'h0101_0101;
                else if (size == 2) wdata = (d & 32'hFFFF) * 32'h0001_0001;
                else                wdata = d;
            end
            if (delay >= TO) begin
                flt = 1; waitc = TO;
            end else begin
                flt = err; waitc = delay + 1;
            end
            if (is_ld && !flt) begin
                v = rdata >> (8 * off);
                if (size == 1) begin
                    v = v & 32'hFF;
                    if (sgn && v >= 32'd128) v = v - 32'd256;
                end else if (size == 2) begin
                    v = v & 32'hFFFF;
                    if (sgn && v >= 32'd32768) v = v - 32'd65536;
                end
                res = v;
            end
        end
        rwo = rw && !flt;
    endtask

    task automatic scramble_inputs();
        result_in_lsu         = $urandom;
        lsu_write_data_in_lsu = $urandom;
        lsu_read_in_lsu       = 3'($urandom_range(0, 7));
        lsu_write_in_lsu      = 2'($urandom_range(0, 3));
        rd_in_lsu             = 4'($urandom);
        reg_write_in_lsu      = 1'($urandom);
    endtask

    // One complete transaction from IDLE back to IDLE, checked against the model.
    task automatic run_txn(input logic [2:0] rop, input logic [1:0] wop,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] rdi, input logic rw,
                           input logic [31:0] rdata, input logic err,
                           input int delay, input int req_stall, input int wbu_stall);
        bit e_bus, e_wen, e_flt, e_rwo;
        logic [3:0] e_strb;
        logic [31:0] e_wdata, e_res;
        int e_wait, n;
        model(rop, wop, a, d, rdata, err, delay, rw,
              e_bus, e_wen, e_strb, e_wdata, e_res, e_flt, e_rwo, e_wait);

        total++; if (is_req_ready_to_exu !== 1'b1) begin bad++; $display("FAIL idle_ready got=%0b want=1", is_req_ready_to_exu); end
        result_in_lsu = a; lsu_write_data_in_lsu = d; lsu_read_in_lsu = rop;
        lsu_write_in_lsu = wop; rd_in_lsu = rdi; reg_write_in_lsu = rw;
        is_req_valid_from_exu = 1'b1;
        @(posedge clk); #1;
        is_req_valid_from_exu = 1'b0;
        scramble_inputs();

        if (e_bus) begin
            for (int s = 0; s <= req_stall; s++) begin
                total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL req_valid got=%0b want=1", mem_req_valid); end
                total++; if (mem_addr !== {a[31:2], 2'b00}) begin bad++; $display("FAIL mem_addr got=%h want=%h", mem_addr, {a[31:2], 2'b00}); end
                total++; if (mem_wen !== e_wen) begin bad++; $display("FAIL mem_wen got=%0b want=%0b", mem_wen, e_wen); end
                total++; if (mem_wstrb !== e_strb) begin bad++; $display("FAIL mem_wstrb got=%b want=%b", mem_wstrb, e_strb); end
                if (e_wen) begin
                    total++; if (mem_wdata !== e_wdata) begin bad++; $display("FAIL mem_wdata got=%h want=%h", mem_wdata, e_wdata); end
                end
                total++; if (is_req_ready_to_exu !== 1'b0) begin bad++; $display("FAIL req_backpressure got=%0b want=0", is_req_ready_to_exu); end
                mem_req_ready = (s == req_stall);
                @(posedge clk); #1;
            end
            mem_req_ready = 1'b0;
            total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL wait_req_valid got=%0b want=0", mem_req_valid); end
            n = 0;
            while (is_req_valid_to_wbu !== 1'b1 && n < 12) begin
                total++; if (is_req_ready_to_exu !== 1'b0) begin bad++; $display("FAIL wait_backpressure got=%0b want=0", is_req_ready_to_exu); end
                mem_rsp_valid = (n == delay);
                mem_rsp_rdata = (n == delay) ? rdata : $urandom;
                mem_rsp_err   = (n == delay) ? err : 1'b0;
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
                n++;
            end
            total++; if (n != e_wait) begin bad++; $display("FAIL wait_cycles got=%0d want=%0d", n, e_wait); end
        end else begin
            total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL no_bus_req got=%0b want=0", mem_req_valid); end
        end

        for (int s = 0; s <= wbu_stall; s++) begin
            total++; if (is_req_valid_to_wbu !== 1'b1) begin bad++; $display("FAIL wbu_valid got=%0b want=1", is_req_valid_to_wbu); end
            total++; if (is_data_forward_valid_from_lsu !== 1'b1) begin bad++; $display("FAIL fwd_valid got=%0b want=1", is_data_forward_valid_from_lsu); end
            total++; if (access_fault_out_lsu !== e_flt) begin bad++; $display("FAIL fault got=%0b want=%0b", access_fault_out_lsu, e_flt); end
            total++; if (reg_write_out_lsu !== e_rwo) begin bad++; $display("FAIL reg_write got=%0b want=%0b", reg_write_out_lsu, e_rwo); end
            total++; if (rd_out_lsu !== rdi) begin bad++; $display("FAIL rd_out got=%0d want=%0d", rd_out_lsu, rdi); end
            if (!e_flt) begin
                total++; if (result_out_lsu !== e_res) begin bad++; $display("FAIL result got=%h want=%h", result_out_lsu, e_res); end
            end
            if (s < wbu_stall) begin
                total++; if (is_req_ready_to_exu !== 1'b0) begin bad++; $display("FAIL done_stall_ready got=%0b want=0", is_req_ready_to_exu); end
            end else begin
                is_req_ready_from_wbu = 1'b1;
                #1;
                total++; if (is_req_ready_to_exu !== 1'b1) begin bad++; $display("FAIL done_drain_ready got=%0b want=1", is_req_ready_to_exu); end
            end
            last_result = result_out_lsu; last_fault = access_fault_out_lsu; last_rw = reg_write_out_lsu;
            @(posedge clk); #1;
        end
        is_req_ready_from_wbu = 1'b0;
        total++; if (is_req_valid_to_wbu !== 1'b0) begin bad++; $display("FAIL back_to_idle got=%0b want=0", is_req_valid_to_wbu); end
        txn_no++;
        $display("txn %0d rop=%0d wop=%0d addr=%h bus=%0b res=%h fault=%0b rw=%0b", txn_no, rop, wop, a, e_bus, last_result, last_fault, last_rw);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (is_req_valid_to_wbu !== 1'b0) begin bad++; $display("FAIL rst_wbu_valid got=%0b want=0", is_req_valid_to_wbu); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0b want=0", mem_req_valid); end
        total++; if (result_out_lsu !== 32'd0) begin bad++; $display("FAIL rst_result got=%h want=0", result_out_lsu); end
        total++; if (access_fault_out_lsu !== 1'b0) begin bad++; $display("FAIL rst_fault got=%0b want=0", access_fault_out_lsu); end
        total++; if (mem_wstrb !== 4'd0) begin bad++; $display("FAIL rst_wstrb got=%b want=0", mem_wstrb); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (is_req_ready_to_exu !== 1'b1) begin bad++; $display("FAIL rst_exit_ready got=%0b want=1", is_req_ready_to_exu); end
        $display("txn reset released");
    endtask

    task automatic test_passthrough();
        run_txn(3'd0, 2'd0, 32'h0000_1234, 32'h0, 4'd5, 1'b1, 32'h0, 1'b0, 0, 0, 0);
        total++; if (last_result !== 32'h0000_1234) begin bad++; $display("FAIL pass_result got=%h want=00001234", last_result); end
        // codes 6/7 behave as no access
        run_txn(3'd7, 2'd0, 32'hDEAD_BEE1, 32'h0, 4'd3, 1'b1, 32'h0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_loads();
        run_txn(3'd1, 2'd0, 32'h8000_0003, 32'h0, 4'd1, 1'b1, 32'h80FF_FF7F, 1'b0, 1, 0, 0);
        total++; if (last_result !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_result got=%h want=ffffff80", last_result); end
        run_txn(3'd4, 2'd0, 32'h8000_0003, 32'h0, 4'd1, 1'b1, 32'h80FF_FF7F, 1'b0, 0, 1, 0);
        total++; if (last_result !== 32'h0000_0080) begin bad++; $display("FAIL lbu_result got=%h want=00000080", last_result); end
        run_txn(3'd2, 2'd0, 32'h0000_0202, 32'h0, 4'd2, 1'b1, 32'h9234_5678, 1'b0, 2, 0, 0);
        run_txn(3'd5, 2'd0, 32'h0000_0202, 32'h0, 4'd2, 1'b1, 32'h9234_5678, 1'b0, 0, 0, 0);
        run_txn(3'd3, 2'd1, 32'h0000_0300, 32'h55, 4'd9, 1'b1, 32'hCAFE_F00D, 1'b0, 3, 2, 0);
    endtask

    task automatic test_store();
        run_txn(3'd0, 2'd2, 32'h0000_0102, 32'h0000_ABCD, 4'd0, 1'b0, 32'h0, 1'b0, 1, 1, 0);
        total++; if (last_rw !== 1'b0) begin bad++; $display("FAIL sh_reg_write got=%0b want=0", last_rw); end
        run_txn(3'd0, 2'd1, 32'h0000_0011, 32'h1234_56A5, 4'd4, 1'b1, 32'h0, 1'b0, 0, 0, 0);
        run_txn(3'd0, 2'd3, 32'h0000_0020, 32'h1234_5678, 4'd6, 1'b1, 32'h0, 1'b0, 2, 0, 0);
    endtask

    task automatic test_faults();
        run_txn(3'd3, 2'd0, 32'h0000_0101, 32'h0, 4'd7, 1'b1, 32'h0, 1'b0, 0, 0, 0);
        total++; if (last_fault !== 1'b1) begin bad++; $display("FAIL misaligned_fault got=%0b want=1", last_fault); end
        run_txn(3'd0, 2'd2, 32'h0000_0103, 32'h1, 4'd7, 1'b1, 32'h0, 1'b0, 0, 0, 0);
        run_txn(3'd3, 2'd0, 32'h0000_0100, 32'h0, 4'd7, 1'b1, 32'h1111_2222, 1'b1, 1, 0, 0);
        total++; if (last_fault !== 1'b1) begin bad++; $display("FAIL err_fault got=%0b want=1", last_fault); end
    endtask

    task automatic test_timeout();
        run_txn(3'd3, 2'd0, 32'h0000_0100, 32'h0, 4'd8, 1'b1, 32'h0, 1'b0, 9, 0, 0);
        total++; if (last_fault !== 1'b1) begin bad++; $display("FAIL timeout_fault got=%0b want=1", last_fault); end
        // response on the final allowed cycle beats the timeout
        run_txn(3'd3, 2'd0, 32'h0000_0104, 32'h0, 4'd8, 1'b1, 32'h0F0F_0F0F, 1'b0, TO - 1, 0, 0);
    endtask

    task automatic test_stall_back_to_back();
        run_txn(3'd0, 2'd0, 32'h0000_0AAA, 32'h0, 4'd1, 1'b1, 32'h0, 1'b0, 0, 0, 3);
        // request A, then hold B on the EXU port while WBU stalls
        result_in_lsu = 32'h0000_1111; lsu_read_in_lsu = 3'd0; lsu_write_in_lsu = 2'd0;
        rd_in_lsu = 4'd2; reg_write_in_lsu = 1'b1; is_req_valid_from_exu = 1'b1;
        @(posedge clk); #1;
        result_in_lsu = 32'h0000_2222; rd_in_lsu = 4'd3;
        for (int s = 0; s < 3; s++) begin
            total++; if (result_out_lsu !== 32'h0000_1111) begin bad++; $display("FAIL stall_hold_result got=%h want=00001111", result_out_lsu); end
            total++; if (is_req_ready_to_exu !== 1'b0) begin bad++; $display("FAIL stall_ready got=%0b want=0", is_req_ready_to_exu); end
            @(posedge clk); #1;
        end
        is_req_ready_from_wbu = 1'b1;
        #1;
        total++; if (is_req_ready_to_exu !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b want=1", is_req_ready_to_exu); end
        @(posedge clk); #1;
        is_req_valid_from_exu = 1'b0; is_req_ready_from_wbu = 1'b0;
        total++; if (is_req_valid_to_wbu !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b want=1", is_req_valid_to_wbu); end
        total++; if (result_out_lsu !== 32'h0000_2222) begin bad++; $display("FAIL b2b_result got=%h want=00002222", result_out_lsu); end
        total++; if (rd_out_lsu !== 4'd3) begin bad++; $display("FAIL b2b_rd got=%0d want=3", rd_out_lsu); end
        is_req_ready_from_wbu = 1'b1;
        @(posedge clk); #1;
        is_req_ready_from_wbu = 1'b0;
        $display("txn back_to_back result=%h", 32'h0000_2222);
    endtask

    task automatic test_reset_mid_access();
        result_in_lsu = 32'h0000_0200; lsu_write_data_in_lsu = 32'h7777_8888;
        lsu_read_in_lsu = 3'd0; lsu_write_in_lsu = 2'd3; rd_in_lsu = 4'd4; reg_write_in_lsu = 1'b1;
        is_req_valid_from_exu = 1'b1;
        @(posedge clk); #1;
        is_req_valid_from_exu = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL midrst_wen got=%0b want=0", mem_wen); end
        total++; if (mem_wstrb !== 4'd0) begin bad++; $display("FAIL midrst_wstrb got=%b want=0", mem_wstrb); end
        total++; if (is_req_valid_to_wbu !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", is_req_valid_to_wbu); end
        total++; if (rd_out_lsu !== 4'd0) begin bad++; $display("FAIL midrst_rd got=%0d want=0", rd_out_lsu); end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        total++; if (is_req_valid_to_wbu !== 1'b0) begin bad++; $display("FAIL late_rsp_valid got=%0b want=0", is_req_valid_to_wbu); end
        total++; if (access_fault_out_lsu !== 1'b0) begin bad++; $display("FAIL late_rsp_fault got=%0b want=0", access_fault_out_lsu); end
        total++; if (is_req_ready_to_exu !== 1'b1) begin bad++; $display("FAIL late_rsp_ready got=%0b want=1", is_req_ready_to_exu); end
        $display("txn reset_mid_access done");
    endtask

    task automatic test_random();
        logic [2:0] rop;
        logic [1:0] wop;
        int k, dly;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 3);
            case (k)
                0:       begin rop = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(6, 7)); wop = 2'd0; end
                1:       begin rop = 3'($urandom_range(1, 5)); wop = 2'd0; end
                2:       begin rop = 3'd0; wop = 2'($urandom_range(1, 3)); end
                default: begin rop = 3'($urandom_range(1, 5)); wop = 2'($urandom_range(1, 3)); end
            endcase
            dly = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, TO - 1);
            run_txn(rop, wop, $urandom, $urandom, 4'($urandom), 1'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0), dly, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst = 1'b1;
        is_req_valid_from_exu = 1'b0; is_req_ready_from_wbu = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0; mem_rsp_err = 1'b0;
        result_in_lsu = 32'd0; lsu_write_data_in_lsu = 32'd0; lsu_read_in_lsu = 3'd0;
        lsu_write_in_lsu = 2'd0; rd_in_lsu = 4'd0; reg_write_in_lsu = 1'b0;
        last_result = 32'd0; last_fault = 1'b0; last_rw = 1'b0;
        test_reset();
        test_passthrough();
        test_loads();
        test_store();
        test_faults();
        test_timeout();
        test_stall_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
